hit_judge_sched: RTL
====================

Name: hit_judge_sched

Overview:
- Sequences the score datapath of the rhythm game.
- Receives note-arrival events from the note scroller and debounced lane buttons, opens a timing window per note and judges hit or miss.
- Maintains the combo count and issues exactly one single-cycle judged `inp` code per note to the score counter, alongside `combo`.
- `inp` is 00 at all other times, so the score counter adds nothing.

Parameters:
- WIN_CYCLES, 24'd5000000: hit window length in clk cycles (100 ms at 50 MHz).
- CNT_W, 24: width of the window counter; must hold WIN_CYCLES.
- COMBO_MAX, 8'd255: saturation value of `combo`.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- game_active  in  1  level; 0 aborts judging and holds the block idle.
- note_valid  in  1  one-cycle pulse: a note reached the hit line.
- note_lanes  in  2  lane mask of that note ([0]=left, [1]=right); 00 is illegal and ignored.
- btn  in  2  debounced lane button levels.
- inp  out  2  judged hit mask to score counter; non-zero only in COMMIT.
- combo  out  8  current combo, to score counter and display.
- hit_pulse  out  1  one cycle, in COMMIT, when the note was fully hit.
- miss_pulse  out  1  one cycle when a note is judged miss or dropped.
- busy  out  1  1 when state != IDLE.

Behaviour:
- Reset (`reset`=0):
  - Outputs: `inp`=00, `combo`=0, `hit_pulse`=0, `miss_pulse`=0, `busy`=0.
  - Internal: state=IDLE, pending empty, window counter=0, hit mask=00, btn history=00.
  - Applies immediately mid-window; a judgment in progress is discarded with no pulse.
- Edge detect: `rise = btn & ~btn_q`; `btn_q` is registered every cycle. Only rising edges count.
- States: IDLE, OPEN, COMMIT.
- IDLE:
  - Selects the next note: a pulse on `note_valid` (with `note_lanes` != 00) that cycle, or the pending slot if it is full.
  - If both exist, the pending slot wins and the new note goes into pending.
  - On selection: latch req=lanes, hit mask=00, counter=0, go to OPEN.
  - Presses in IDLE are ignored (no penalty).
- OPEN:
  - hit mask |= (rise & req) each cycle; presses on lanes not in req are ignored.
  - Counter increments by 1 per cycle.
  - Exit to COMMIT when (hit mask | (rise & req)) == req (early-complete), or when counter == WIN_CYCLES-1.
- Judging on the OPEN->COMMIT edge (all outputs registered on this edge):
  - `inp` <= final hit mask (partial hits are still scored).
  - Full hit: `combo` <= min(`combo`+1, COMBO_MAX); `hit_pulse` <= 1.
  - Otherwise: `combo` <= 0; `miss_pulse` <= 1.
- COMMIT:
  - Lasts exactly one cycle; outputs are valid here, so the score counter samples the new `combo` and `inp` on the edge that leaves COMMIT.
  - Next edge: `inp` <= 00, pulses <= 0, state <= IDLE.
  - A new note is never selected directly from COMMIT.
- Pending slot:
  - Depth 1. A `note_valid` arriving in OPEN or COMMIT is stored if the slot is empty.
  - If the slot is full, the new note is dropped: `combo` <= 0, `miss_pulse` for one cycle. The current window continues.
  - If a drop coincides with a COMMIT judgment, the combo result is 0 and `miss_pulse`=1.
- `game_active`=0:
  - Synchronous abort: next state IDLE, pending cleared, `inp`=00, `combo` unchanged, no pulses.
  - `note_valid` is ignored while `game_active`=0.
- Latency: note -> earliest `inp` = 3 cycles (IDLE select, one OPEN cycle with a hit, COMMIT). A miss takes WIN_CYCLES+1 cycles from selection to COMMIT.
- Widths: counter is CNT_W unsigned and never wraps, since it exits at WIN_CYCLES-1. `combo` saturates at COMMIT and never wraps to 0 by overflow.

Decomposition:
- Shared package `game_pkg`:
  - State encoding localparams: ST_IDLE, ST_OPEN, ST_COMMIT.
  - Lane constants: LANE_L=2'b01, LANE_R=2'b10, LANE_BOTH=2'b11.
  - COMBO_MAX.
- One sub-module `btn_edge`: parameterised-width rising-edge detector with async active-low reset. Everything else stays in this module.

Test Plan:
- WIN_CYCLES=8; reset release; `note_lanes`=01; `btn[0]` rises 2 cycles into OPEN -> `inp`=01 for one cycle, `combo` 0->1, `hit_pulse`=1, back to IDLE after.
- Note 11, only `btn[1]` pressed -> after 8 OPEN cycles: `inp`=10, `combo`=0, `miss_pulse`=1. The score counter adds 32.
- Preload `combo`=255 via 255 hits, then one more full hit -> `combo` stays 255, `hit_pulse`=1.
- Three `note_valid` pulses 1 cycle apart -> the second goes to pending and is judged next; the third is dropped with `miss_pulse` and `combo`=0.
- `btn` held high before the note arrives -> no rise, judged miss. Press in IDLE -> no effect on `combo`.
- `reset` low mid-OPEN and `game_active` low mid-OPEN -> IDLE next cycle, `inp`=00, no pulses; reset also clears `combo` and pending.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the rhythm-game score datapath.
package game_pkg;

    // Judge FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Lane masks
    localparam logic [1:0] LANE_L    = 2'b01;
    localparam logic [1:0] LANE_R    = 2'b10;
    localparam logic [1:0] LANE_BOTH = 2'b11;

    // Combo saturation value
    localparam logic [7:0] COMBO_MAX = 8'd255;

    // Saturating combo increment
    function automatic logic [7:0] combo_inc(input logic [7:0] c, input logic [7:0] max);
        return (c >= max) ? max : (c + 8'd1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a bus of debounced button levels.
module btn_edge #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] btn_q;

    // Button history, sampled every cycle regardless of judge state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= '0;
        end else begin
            btn_q <= din;
        end
    end

    assign rise = din & ~btn_q;

endmodule

// File: rtl/hit_judge_sched.sv
// Hit/miss judge: opens a timing window per note, tracks combo and emits
// one single-cycle judged lane mask per note to the score counter.
module hit_judge_sched #(
    parameter int unsigned      CNT_W      = 24,
    parameter logic [CNT_W-1:0] WIN_CYCLES = 24'd5000000,
    parameter logic [7:0]       COMBO_MAX  = game_pkg::COMBO_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_active,
    input  logic       note_valid,
    input  logic [1:0] note_lanes,
    input  logic [1:0] btn,
    output logic [1:0] inp,
    output logic [7:0] combo,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       busy
);

    import game_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       req_q, req_d;
    logic [1:0]       hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_v_q, pend_v_d;
    logic [1:0]       pend_l_q, pend_l_d;
    logic [1:0]       inp_q, inp_d;
    logic [7:0]       combo_q, combo_d;
    logic             hit_pulse_q, hit_pulse_d;
    logic             miss_pulse_q, miss_pulse_d;

    logic [1:0]       rise;
    logic [1:0]       hit_now;
    logic             new_note;
    logic             win_done;

    btn_edge #(
        .WIDTH (2)
    ) u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .din   (btn),
        .rise  (rise)
    );

    assign hit_now  = hit_q | (rise & req_q);
    assign new_note = note_valid && (note_lanes != 2'b00);
    assign win_done = (hit_now == req_q) || (cnt_q == CNT_LAST);

    // Next-state: window sequencing, judging and pending-slot management
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        hit_d        = hit_q;
        cnt_d        = cnt_q;
        pend_v_d     = pend_v_q;
        pend_l_d     = pend_l_q;
        inp_d        = 2'b00;
        combo_d      = combo_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        if (!game_active) begin
            // Abort: drop everything except the combo
            state_d  = ST_IDLE;
            pend_v_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_v_q) begin
                        // Older pending note goes first; a new note refills the slot
                        req_d    = pend_l_q;
                        hit_d    = 2'b00;
                        cnt_d    = '0;
                        state_d  = ST_OPEN;
                        pend_v_d = new_note;
                        if (new_note) begin
                            pend_l_d = note_lanes;
                        end
                    end else if (new_note) begin
                        req_d   = note_lanes;
                        hit_d   = 2'b00;
                        cnt_d   = '0;
                        state_d = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    hit_d = hit_now;
                    cnt_d = cnt_q + CNT_ONE;
                    if (win_done) begin
                        state_d = ST_COMMIT;
                        inp_d   = hit_now;
                        if (hit_now == req_q) begin
                            combo_d     = combo_inc(combo_q, COMBO_MAX);
                            hit_pulse_d = 1'b1;
                        end else begin
                            combo_d      = 8'd0;
                            miss_pulse_d = 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Notes arriving while a window is active are queued or dropped;
            // a drop overrides any combo result computed above.
            if ((state_q != ST_IDLE) && new_note) begin
                if (!pend_v_q) begin
                    pend_v_d = 1'b1;
                    pend_l_d = note_lanes;
                end else begin
                    combo_d      = 8'd0;
                    miss_pulse_d = 1'b1;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_q        <= 2'b00;
            hit_q        <= 2'b00;
            cnt_q        <= '0;
            pend_v_q     <= 1'b0;
            pend_l_q     <= 2'b00;
            inp_q        <= 2'b00;
            combo_q      <= 8'd0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            hit_q        <= hit_d;
            cnt_q        <= cnt_d;
            pend_v_q     <= pend_v_d;
            pend_l_q     <= pend_l_d;
            inp_q        <= inp_d;
            combo_q      <= combo_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    assign inp        = inp_q;
    assign combo      = combo_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
